// File: rtl/vending_machine_multicoin_if.sv
// Coin-acceptor / dispenser / change-hopper signal bundle for the multicoin vending machine.
// The master modport drives coins and cancel; the slave modport is the machine itself.
interface vending_machine_multicoin_if #(
    parameter int CREDIT_W = 10
);
    logic                N_in;
    logic                T_in;
    logic                Q_in;
    logic                D_in;
    logic                cancel;
    logic                dispense;
    logic                change;
    logic                ret_q;
    logic                ret_t;
    logic                ret_n;
    logic                reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output N_in, T_in, Q_in, D_in, cancel,
        input  dispense, change, ret_q, ret_t, ret_n, reject, busy, credit
    );

    modport slave (
        input  N_in, T_in, Q_in, D_in, cancel,
        output dispense, change, ret_q, ret_t, ret_n, reject, busy, credit
    );
endinterface

// File: rtl/vending_machine_multicoin.sv
// Multicoin vending machine: collects 5/10/25/100c toward PRICE, vends for one cycle,
// then pays change serially (greedy quarters/dimes/nickels), one coin per cycle.
module vending_machine_multicoin #(
    parameter int PRICE    = 75,
    parameter int CREDIT_W = 10
) (
    input  logic                           clk,
    input  logic                           rstn,
    vending_machine_multicoin_if.slave     bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] VAL_N   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] VAL_T   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] VAL_Q   = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] VAL_D   = CREDIT_W'(100);

    // Value of the inserted coin; only meaningful when exactly one input is high.
    function automatic logic [CREDIT_W-1:0] coin_value(
        input logic n, input logic t, input logic q, input logic d
    );
        logic [CREDIT_W-1:0] v;
        v = '0;
        if (d)      v = VAL_D;
        else if (q) v = VAL_Q;
        else if (t) v = VAL_T;
        else if (n) v = VAL_N;
        return v;
    endfunction

    // Greedy pick of the next coin to return for the given remaining change.
    function automatic logic [CREDIT_W-1:0] change_coin(input logic [CREDIT_W-1:0] c);
        logic [CREDIT_W-1:0] v;
        if (c >= VAL_Q)      v = VAL_Q;
        else if (c >= VAL_T) v = VAL_T;
        else                 v = VAL_N;
        return v;
    endfunction

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                reject_reg, reject_next;

    logic [3:0]          coins;
    logic                single_coin;
    logic                multi_coin;
    logic                any_coin;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] ret_value;

    assign coins       = {bus.D_in, bus.Q_in, bus.T_in, bus.N_in};
    assign any_coin    = |coins;
    assign single_coin = ($countones(coins) == 1);
    assign multi_coin  = ($countones(coins) > 1);
    assign sum         = credit_reg + coin_value(bus.N_in, bus.T_in, bus.Q_in, bus.D_in);
    assign ret_value   = change_coin(credit_reg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= COLLECT;
            credit_reg <= '0;
            reject_reg <= 1'b0;
        end else begin
            state      <= state_next;
            credit_reg <= credit_next;
            reject_reg <= reject_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit_reg;
        reject_next = multi_coin || (any_coin && (state != COLLECT));

        case (state)
            COLLECT: begin
                if (single_coin) begin
                    // A completing coin always vends; a simultaneous cancel loses.
                    if (sum >= PRICE_C) begin
                        credit_next = sum - PRICE_C;
                        state_next  = VEND;
                    end else if (bus.cancel) begin
                        credit_next = sum;
                        state_next  = CHANGE;
                    end else begin
                        credit_next = sum;
                    end
                end else if (!any_coin && bus.cancel && (credit_reg != '0)) begin
                    state_next = CHANGE;
                end
            end

            VEND: begin
                state_next = (credit_reg != '0) ? CHANGE : COLLECT;
            end

            CHANGE: begin
                // Guarding with <= keeps a stray zero credit from wrapping around.
                if (credit_reg <= ret_value) begin
                    credit_next = '0;
                    state_next  = COLLECT;
                end else begin
                    credit_next = credit_reg - ret_value;
                end
            end

            default: begin
                state_next  = COLLECT;
                credit_next = '0;
            end
        endcase
    end

    assign bus.dispense = (state == VEND);
    assign bus.change   = (state == CHANGE);
    assign bus.ret_q    = (state == CHANGE) && (credit_reg >= VAL_Q);
    assign bus.ret_t    = (state == CHANGE) && (credit_reg <  VAL_Q) && (credit_reg >= VAL_T);
    assign bus.ret_n    = (state == CHANGE) && (credit_reg <  VAL_T);
    assign bus.reject   = reject_reg;
    assign bus.busy     = (state != COLLECT);
    assign bus.credit   = credit_reg;

endmodule
